// File: rtl/hpu_qualified_pipe_elastic.sv
// ---------------------------------------------------------------------------
// hpu_qualified_pipe_elastic
//
// DEPTH-stage elastic pipeline carrying a data field and a control field,
// with valid/ready handshakes on both sides. Empty stages always accept,
// so backpressure stalls only the occupied tail of the pipe (bubbles
// collapse). A synchronous flush empties the pipe. The occupancy output
// counts the valid stages.
//
// Ports:
//   clk        clock, all logic on posedge
//   s_rst      synchronous reset, active-high
//   flush      discard all pipe contents this cycle
//   in_vld     input entry valid
//   in_rdy     pipe accepts input this cycle (combinational from out_rdy)
//   in_data    input payload  [DATA_WIDTH]
//   in_ctrl    input control  [CTRL_WIDTH]
//   out_vld    output entry valid (stage DEPTH-1)
//   out_rdy    downstream accepts
//   out_data   output payload [DATA_WIDTH]
//   out_ctrl   output control [CTRL_WIDTH]
//   occupancy  number of valid stages [$clog2(DEPTH+1)]
// ---------------------------------------------------------------------------
module hpu_qualified_pipe_elastic #(
    parameter int                    DEPTH      = 2,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    CTRL_WIDTH = 32,
    parameter logic [CTRL_WIDTH-1:0] CTRL_RST   = '0
) (
    input  logic                         clk,
    input  logic                         s_rst,
    input  logic                         flush,
    input  logic                         in_vld,
    output logic                         in_rdy,
    input  logic [DATA_WIDTH-1:0]        in_data,
    input  logic [CTRL_WIDTH-1:0]        in_ctrl,
    output logic                         out_vld,
    input  logic                         out_rdy,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [CTRL_WIDTH-1:0]        out_ctrl,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]      vld_q;
    logic [DATA_WIDTH-1:0] data_q   [DEPTH];
    logic [CTRL_WIDTH-1:0] ctrl_q   [DEPTH];

    logic [DEPTH-1:0]      adv;
    logic [DEPTH-1:0]      src_vld;
    logic [DATA_WIDTH-1:0] src_data [DEPTH];
    logic [CTRL_WIDTH-1:0] src_ctrl [DEPTH];

    logic                  in_xfer;
    logic                  out_xfer;

    // NOTE: every signal driven here gets a value on every path (defaults
    // first), otherwise synthesis infers a latch.
    always_comb begin
        adv     = '0;
        src_vld = '0;
        for (int i = 0; i < DEPTH; i++) begin
            src_data[i] = '0;
            src_ctrl[i] = '0;
        end

        // Stage i may advance when downstream accepts or when any stage at or
        // after i is empty. This is the !vld[i] | adv[i+1] chain unrolled, so
        // adv has no dependency on itself.
        for (int i = 0; i < DEPTH; i++) begin
            adv[i] = out_rdy || (|(~vld_q & ({DEPTH{1'b1}} << i)));
        end

        // Upstream source of each stage: the input port for stage 0.
        src_vld[0]  = in_vld;
        src_data[0] = in_data;
        src_ctrl[0] = in_ctrl;
        for (int i = 1; i < DEPTH; i++) begin
            src_vld[i]  = vld_q[i-1];
            src_data[i] = data_q[i-1];
            src_ctrl[i] = ctrl_q[i-1];
        end
    end

    // Flush blocks both handshakes for the cycle it is asserted.
    assign in_rdy   = adv[0] && !flush;
    assign out_vld  = vld_q[DEPTH-1] && !flush;
    assign out_data = data_q[DEPTH-1];
    assign out_ctrl = ctrl_q[DEPTH-1];

    assign in_xfer  = in_vld && in_rdy;
    assign out_xfer = out_vld && out_rdy;

    // NOTE: state registers use non-blocking assignments so every stage
    // samples the pre-edge value of its upstream neighbour.
    always_ff @(posedge clk) begin
        if (s_rst || flush) begin
            vld_q     <= '0;
            occupancy <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ctrl_q[i] <= CTRL_RST;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (adv[i]) begin
                    vld_q[i] <= src_vld[i];
                    // A bubble moving in leaves the old ctrl in place.
                    if (src_vld[i]) begin
                        ctrl_q[i] <= src_ctrl[i];
                    end
                end
            end
            occupancy <= occupancy + OCC_W'(in_xfer) - OCC_W'(out_xfer);
        end
    end

    // NOTE: the payload registers carry no reset; vld_q qualifies them, and
    // leaving them out of reset keeps the reset tree small.
    always_ff @(posedge clk) begin
        if (!flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (adv[i] && src_vld[i]) begin
                    data_q[i] <= src_data[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_hpu_qualified_pipe_elastic.sv
// ---------------------------------------------------------------------------
// tb_hpu_qualified_pipe_elastic
//
// Bench for hpu_qualified_pipe_elastic at DEPTH=3. The reference model is a
// queue of in-flight entries, each tagged with its pipe position. Every cycle
// each entry, oldest first, moves one position forward unless the entry ahead
// of it blocks. Directed sequences pin the model with literal values. A
// random phase then runs against the same model.
// ---------------------------------------------------------------------------
module tb_hpu_qualified_pipe_elastic;

    localparam int         DEPTH    = 3;
    localparam int         DW       = 16;
    localparam int         CW       = 8;
    localparam logic [7:0] CTRL_RST = 8'h5A;

    logic          clk = 1'b0;
    logic          s_rst;
    logic          flush;
    logic          in_vld;
    logic          in_rdy;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          out_vld;
    logic          out_rdy;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic [1:0]    occupancy;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    hpu_qualified_pipe_elastic #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DW),
        .CTRL_WIDTH (CW),
        .CTRL_RST   (CTRL_RST)
    ) dut (
        .clk       (clk),
        .s_rst     (s_rst),
        .flush     (flush),
        .in_vld    (in_vld),
        .in_rdy    (in_rdy),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_vld   (out_vld),
        .out_rdy   (out_rdy),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
        int            pos;
    } ent_t;

    ent_t       mq[$];     // index 0 is the oldest entry
    logic [7:0] last_ctrl; // ctrl most recently held by the output stage

    // Position still free for a new entry after every in-flight entry has
    // moved as far as it can this cycle; >= 0 means position 0 is available.
    function automatic int tail_limit();
        int lim;
        int np;
        lim = out_rdy ? DEPTH : DEPTH - 1;
        foreach (mq[k]) begin
            np  = (mq[k].pos + 1 < lim) ? mq[k].pos + 1 : lim;
            lim = np - 1;
        end
        return lim;
    endfunction

    always @(posedge clk) begin
        int lim;
        int np;
        bit pop;
        if (s_rst || flush) begin
            mq.delete();
            last_ctrl = CTRL_RST;
        end else begin
            lim = out_rdy ? DEPTH : DEPTH - 1;
            pop = 1'b0;
            foreach (mq[k]) begin
                np  = (mq[k].pos + 1 < lim) ? mq[k].pos + 1 : lim;
                lim = np - 1;
                if (np == DEPTH) begin
                    pop = 1'b1;
                end else begin
                    if (np == DEPTH - 1 && mq[k].pos != DEPTH - 1) last_ctrl = mq[k].c;
                    mq[k].pos = np;
                end
            end
            if (pop) void'(mq.pop_front());
            if (in_vld && lim >= 0) mq.push_back('{in_data, in_ctrl, 0});
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        bit head;
        bit e_vld;
        bit e_rdy;
        if (chk_en) begin
            head  = (mq.size() > 0) && (mq[0].pos == DEPTH - 1);
            e_vld = head && !flush;
            e_rdy = !flush && (tail_limit() >= 0);
            check("m_in_rdy",    32'(in_rdy),    32'(e_rdy));
            check("m_out_vld",   32'(out_vld),   32'(e_vld));
            check("m_occupancy", 32'(occupancy), 32'(mq.size()));
            check("m_out_ctrl",  32'(out_ctrl),  32'(last_ctrl));
            if (e_vld) check("m_out_data", 32'(out_data), 32'(mq[0].d));
        end
    end

    // ---------------- stimulus ----------------
    // Drive one cycle of inputs just after the posedge, then leave time for
    // the combinational outputs to settle so the caller can check them.
    task automatic tick(input logic iv, input logic [DW-1:0] d, input logic ordy, input logic fl);
        @(posedge clk);
        #1;
        in_vld  = iv;
        in_data = d;
        in_ctrl = d[7:0] + 8'd1;
        out_rdy = ordy;
        flush   = fl;
        #2;
    endtask

    initial begin
        s_rst   = 1'b1;
        flush   = 1'b0;
        in_vld  = 1'b1;
        in_data = 16'hDEAD;
        in_ctrl = 8'hEE;
        out_rdy = 1'b0;

        // Reset held for 2 cycles with in_vld high.
        repeat (2) @(posedge clk);
        #1;
        s_rst  = 1'b0;
        in_vld = 1'b0;
        chk_en = 1'b1;
        #2;
        check("rst_out_vld",   32'(out_vld),   32'd0);
        check("rst_out_ctrl",  32'(out_ctrl),  32'h5A);
        check("rst_occupancy", 32'(occupancy), 32'd0);
        check("rst_in_rdy",    32'(in_rdy),    32'd1);

        // Streaming with out_rdy=1: outputs appear 3 cycles after accept.
        tick(1, 16'h0011, 1, 0);
        tick(1, 16'h0022, 1, 0);
        tick(1, 16'h0033, 1, 0);
        tick(0, 16'h0000, 1, 0);
        check("str_vld0", 32'(out_vld),   32'd1);
        check("str_d0",   32'(out_data),  32'h11);
        check("str_occ",  32'(occupancy), 32'd3);
        tick(0, 16'h0000, 1, 0);
        check("str_d1",   32'(out_data),  32'h22);
        tick(0, 16'h0000, 1, 0);
        check("str_d2",   32'(out_data),  32'h33);
        check("str_c2",   32'(out_ctrl),  32'h34);
        tick(0, 16'h0000, 1, 0);
        check("str_empty", 32'(out_vld),  32'd0);

        // Backpressure: fill the pipe with out_rdy=0, then drain it.
        tick(1, 16'h000A, 0, 0);
        tick(1, 16'h000B, 0, 0);
        tick(1, 16'h000C, 0, 0);
        tick(1, 16'h000D, 0, 0);
        check("bp_in_rdy", 32'(in_rdy),    32'd0);
        check("bp_occ",    32'(occupancy), 32'd3);
        check("bp_d",      32'(out_data),  32'hA);
        tick(1, 16'h000D, 0, 0);
        check("bp_hold",   32'(out_data),  32'hA);
        tick(1, 16'h000D, 1, 0);
        check("bp_full_rdy", 32'(in_rdy),  32'd1);
        check("bp_dA",     32'(out_data),  32'hA);
        tick(0, 16'h0000, 1, 0);
        check("bp_occ_eq", 32'(occupancy), 32'd3);
        check("bp_dB",     32'(out_data),  32'hB);
        tick(0, 16'h0000, 1, 0);
        check("bp_dC",     32'(out_data),  32'hC);
        tick(0, 16'h0000, 1, 0);
        check("bp_dD",     32'(out_data),  32'hD);
        tick(0, 16'h0000, 1, 0);
        check("bp_drained", 32'(occupancy), 32'd0);

        // Bubble collapse with out_rdy=0.
        tick(1, 16'h0001, 0, 0);
        tick(0, 16'h0000, 0, 0);
        tick(1, 16'h0002, 0, 0);
        tick(0, 16'h0000, 0, 0);
        tick(0, 16'h0000, 0, 0);
        check("bub_occ",   32'(occupancy), 32'd2);
        check("bub_rdy",   32'(in_rdy),    32'd1);
        check("bub_d",     32'(out_data),  32'h1);
        tick(0, 16'h0000, 1, 0);
        tick(0, 16'h0000, 1, 0);
        check("bub_d2",    32'(out_data),  32'h2);
        tick(0, 16'h0000, 1, 0);

        // Flush with two entries held, in_vld=1 and out_rdy=1 during flush.
        tick(1, 16'h0051, 0, 0);
        tick(1, 16'h0052, 0, 0);
        tick(0, 16'h0000, 0, 0);
        tick(0, 16'h0000, 0, 0);
        check("fl_pre_occ", 32'(occupancy), 32'd2);
        tick(1, 16'h0053, 1, 1);
        check("fl_in_rdy",  32'(in_rdy),  32'd0);
        check("fl_out_vld", 32'(out_vld), 32'd0);
        tick(0, 16'h0000, 1, 0);
        check("fl_occ",     32'(occupancy), 32'd0);
        check("fl_ctrl",    32'(out_ctrl),  32'h5A);
        check("fl_vld",     32'(out_vld),   32'd0);
        repeat (3) tick(0, 16'h0000, 1, 0);
        check("fl_no_cap",  32'(out_vld),   32'd0);

        // Random phase against the model.
        for (int n = 0; n < 10000; n++) begin
            @(posedge clk);
            #1;
            in_vld  = ($urandom_range(0, 9) < 7);
            in_data = 16'($urandom);
            in_ctrl = 8'($urandom);
            out_rdy = ($urandom_range(0, 9) < 6);
            flush   = ($urandom_range(0, 99) < 2);
            s_rst   = ($urandom_range(0, 199) == 0);
        end
        @(posedge clk);
        #1;
        s_rst  = 1'b0;
        flush  = 1'b0;
        in_vld = 1'b0;
        @(negedge clk);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
